joybus_tx: RTL

- Serialises command/response bytes onto the single-wire Joybus line shared by the GameCube controller and N64 console interfaces.
- Drives the line open-drain style: assert pull-low or release.
- Complements the line-sampling debouncer on the receive side.
- Fed by a byte-wide valid/ready stream from the protocol translator; appends the stop bit after the byte flagged last.

---
 rtl/joybus_pkg.sv | 23 ++
 rtl/joybus_qtimer.sv | 58 +++++
 rtl/joybus_tx.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/joybus_pkg.sv
// Shared types and constants for the Joybus transmitter: FSM states,
// per-bit low-quarter patterns and the quarter-cycle counter width.
package joybus_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BIT      = 2'd1,
      STOP     = 2'd2,
      STOP_REL = 2'd3
   } state_t;

   // Number of leading quarters the line is held low for each bit value.
   localparam logic [2:0] BIT0_LOW_Q = 3'd3;
   localparam logic [2:0] BIT1_LOW_Q = 3'd1;

   localparam int CLK_PER_US_MAX = 255;
   localparam int QCYC_W         = $clog2(CLK_PER_US_MAX + 1);

   function automatic logic [2:0] low_quarters(input logic bit_val);
      return bit_val ? BIT1_LOW_Q : BIT0_LOW_Q;
   endfunction

endpackage

// File: rtl/joybus_qtimer.sv
// Quarter-bit timebase: counts qcyc within a quarter and the quarter within a bit,
// with registered end-of-quarter/end-of-bit strobes plus one-cycle look-ahead copies.
module joybus_qtimer
   import joybus_pkg::*;
#(
   parameter int CLK_PER_US = 16
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   output logic [1:0] quarter,
   output logic       quarter_end,
   output logic       bit_end,
   output logic [1:0] quarter_nxt,
   output logic       bit_end_nxt
);

   localparam logic [QCYC_W-1:0] QCYC_LAST = QCYC_W'(CLK_PER_US - 1);

   logic [QCYC_W-1:0] qcyc_r;
   logic [QCYC_W-1:0] qcyc_nxt_s;
   logic              quarter_end_nxt_s;

   // Counter advance; clr restarts the timebase at the start of a new phase.
   always_comb begin
      qcyc_nxt_s  = qcyc_r;
      quarter_nxt = quarter;
      if (clr) begin
         qcyc_nxt_s  = {QCYC_W{1'b0}};
         quarter_nxt = 2'd0;
      end else if (qcyc_r == QCYC_LAST) begin
         qcyc_nxt_s  = {QCYC_W{1'b0}};
         quarter_nxt = quarter + 2'd1;
      end else begin
         qcyc_nxt_s  = qcyc_r + QCYC_W'(1);
         quarter_nxt = quarter;
      end
   end

   assign quarter_end_nxt_s = (qcyc_nxt_s == QCYC_LAST);
   assign bit_end_nxt       = quarter_end_nxt_s && (quarter_nxt == 2'd3);

   always_ff @(posedge clk) begin
      if (rst) begin
         qcyc_r      <= {QCYC_W{1'b0}};
         quarter     <= 2'd0;
         quarter_end <= 1'b0;
         bit_end     <= 1'b0;
      end else begin
         qcyc_r      <= qcyc_nxt_s;
         quarter     <= quarter_nxt;
         quarter_end <= quarter_end_nxt_s;
         bit_end     <= bit_end_nxt;
      end
   end

endmodule

// File: rtl/joybus_tx.sv
// Joybus open-drain byte serialiser with stop bit, zero-gap back-to-back bytes and
// sticky underrun. Optional abort-on-collision when JOYBUS_TX_COLLISION_EN is defined.
module joybus_tx
   import joybus_pkg::*;
#(
   parameter int CLK_PER_US  = 16,
   parameter int STOP_LOW_US = 1
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       line_oe,
   output logic       busy,
   output logic       done,
   output logic       underrun
`ifdef JOYBUS_TX_COLLISION_EN
   ,
   input  logic       line_in,
   output logic       collision
`endif
);

   localparam logic [1:0] STOP_LAST_Q = 2'(STOP_LOW_US - 1);

   state_t     state_r;
   state_t     state_nxt_s;
   logic [7:0] shift_r;
   logic [7:0] shift_nxt_s;
   logic [2:0] bitcnt_r;
   logic [2:0] bitcnt_nxt_s;
   logic       last_r;
   logic       last_nxt_s;
   logic       underrun_nxt_s;
   logic       done_nxt_s;
   logic       line_oe_nxt_s;
   logic       tx_ready_nxt_s;
   logic       accept_s;
   logic       clr_s;

   logic [1:0] quarter_s;
   logic       quarter_end_s;
   logic       bit_end_s;
   logic [1:0] quarter_nxt_s;
   logic       bit_end_nxt_s;

`ifdef JOYBUS_TX_COLLISION_EN
   logic       collision_nxt_s;
   logic       released_s;
`endif

   assign accept_s = tx_valid && tx_ready;
   // Any phase change (and idling) restarts the timebase so each phase begins at quarter 0.
   assign clr_s    = (state_nxt_s != state_r) || (state_nxt_s == IDLE);

   joybus_qtimer #(
      .CLK_PER_US (CLK_PER_US)
   ) u_qtimer (
      .clk         (clk),
      .rst         (rst),
      .clr         (clr_s),
      .quarter     (quarter_s),
      .quarter_end (quarter_end_s),
      .bit_end     (bit_end_s),
      .quarter_nxt (quarter_nxt_s),
      .bit_end_nxt (bit_end_nxt_s)
   );

`ifdef JOYBUS_TX_COLLISION_EN
   assign released_s = ((state_r == BIT) && ({1'b0, quarter_s} >= low_quarters(shift_r[7])))
                       || (state_r == STOP_REL);
`endif

   always_comb begin
      state_nxt_s    = state_r;
      shift_nxt_s    = shift_r;
      bitcnt_nxt_s   = bitcnt_r;
      last_nxt_s     = last_r;
      underrun_nxt_s = underrun;
      done_nxt_s     = 1'b0;
`ifdef JOYBUS_TX_COLLISION_EN
      collision_nxt_s = collision;
`endif
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nxt_s    = BIT;
               shift_nxt_s    = tx_data;
               bitcnt_nxt_s   = 3'd7;
               last_nxt_s     = tx_last;
               underrun_nxt_s = 1'b0;
`ifdef JOYBUS_TX_COLLISION_EN
               collision_nxt_s = 1'b0;
`endif
            end else begin
               state_nxt_s = IDLE;
            end
         end
         BIT: begin
            if (!bit_end_s) begin
               state_nxt_s = BIT;
            end else if (bitcnt_r != 3'd0) begin
               shift_nxt_s  = {shift_r[6:0], 1'b0};
               bitcnt_nxt_s = bitcnt_r - 3'd1;
            end else if (last_r) begin
               state_nxt_s = STOP;
            end else if (accept_s) begin
               // Byte boundary with the next byte waiting: reload with no gap.
               shift_nxt_s  = tx_data;
               bitcnt_nxt_s = 3'd7;
               last_nxt_s   = tx_last;
            end else begin
               underrun_nxt_s = 1'b1;
               state_nxt_s    = STOP;
            end
         end
         STOP: begin
            if (quarter_end_s && (quarter_s == STOP_LAST_Q)) begin
               state_nxt_s = STOP_REL;
            end else begin
               state_nxt_s = STOP;
            end
         end
         STOP_REL: begin
            if (quarter_end_s) begin
               state_nxt_s = IDLE;
               done_nxt_s  = 1'b1;
            end else begin
               state_nxt_s = STOP_REL;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
`ifdef JOYBUS_TX_COLLISION_EN
      // Someone else holding the line low while we release it: abandon the frame.
      if (quarter_end_s && released_s && !line_in) begin
         collision_nxt_s = 1'b1;
         state_nxt_s     = IDLE;
         done_nxt_s      = 1'b0;
      end else begin
         collision_nxt_s = collision_nxt_s;
      end
`endif
   end

   // Output look-ahead so line_oe/tx_ready are registered yet aligned with the new state.
   always_comb begin
      line_oe_nxt_s = 1'b0;
      case (state_nxt_s)
         BIT:     line_oe_nxt_s = ({1'b0, quarter_nxt_s} < low_quarters(shift_nxt_s[7]));
         STOP:    line_oe_nxt_s = 1'b1;
         default: line_oe_nxt_s = 1'b0;
      endcase
      tx_ready_nxt_s = (state_nxt_s == IDLE)
                       || ((state_nxt_s == BIT) && (bitcnt_nxt_s == 3'd0)
                           && !last_nxt_s && bit_end_nxt_s);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         shift_r  <= 8'd0;
         bitcnt_r <= 3'd0;
         last_r   <= 1'b0;
         line_oe  <= 1'b0;
         tx_ready <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         underrun <= 1'b0;
`ifdef JOYBUS_TX_COLLISION_EN
         collision <= 1'b0;
`endif
      end else begin
         state_r  <= state_nxt_s;
         shift_r  <= shift_nxt_s;
         bitcnt_r <= bitcnt_nxt_s;
         last_r   <= last_nxt_s;
         line_oe  <= line_oe_nxt_s;
         tx_ready <= tx_ready_nxt_s;
         busy     <= (state_nxt_s != IDLE);
         done     <= done_nxt_s;
         underrun <= underrun_nxt_s;
`ifdef JOYBUS_TX_COLLISION_EN
         collision <= collision_nxt_s;
`endif
      end
   end

endmodule
